// File: rtl/pipe_pkg.sv
// Shared definitions for the IF/ID pipeline control: NOP encoding, JR opcode,
// FSM state encoding and a saturating-increment helper.
package pipe_pkg;

    // Wide enough for any supported IW; users slice to their own width.
    localparam logic [63:0] NOP_INSTR = 64'b0;
    localparam logic [2:0]  OPC_JR    = 3'b111;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive stall cycles (saturating at 255) and raises a sticky
// timeout flag once the count reaches STALL_MAX.
module stall_watchdog
    import pipe_pkg::*;
#(
    parameter int unsigned STALL_MAX = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic stall,
    output logic timeout
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Any non-stall cycle ends the run of consecutive stalls.
    assign cnt_d = stall ? sat_inc8(cnt_q) : 8'd0;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= 8'd0;
            timeout <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (stall && (cnt_d >= 8'(STALL_MAX))) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_id_stall_ctrl.sv
// IF/ID pipeline register with stall hold, bubble injection and multi-cycle flush.
// Optional statistics counters are enabled by defining IF_ID_STALL_STATS_EN.
module if_id_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned IW           = 16,
    parameter int unsigned AW           = 16,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned STALL_MAX    = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          stall_req,
    input  logic          flush_req,
    input  logic [IW-1:0] instr_in,
    input  logic [AW-1:0] pc_in,
    output logic          pc_write_en,
    output logic [IW-1:0] ifid_instr,
    output logic [AW-1:0] ifid_pc,
    output logic          ifid_valid,
    output logic          idex_bubble,
    output logic          stall_timeout
`ifdef IF_ID_STALL_STATS_EN
    ,
    output logic [31:0]   stat_stall_cycles,
    output logic [31:0]   stat_flush_events,
    output logic [31:0]   stat_nops
`endif
);

    localparam logic [IW-1:0] NOP          = NOP_INSTR[IW-1:0];
    localparam logic [3:0]    FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

    state_t        state_q, state_d;
    logic [3:0]    flush_cnt_q, flush_cnt_d;
    logic [IW-1:0] instr_d;
    logic [AW-1:0] pc_d;
    logic          valid_d;
    logic          load_nop;
    logic          eff_stall;

    // A flush squashes whatever is stalled, and a NOP in ID cannot cause a hazard.
    assign eff_stall   = stall_req & ~flush_req & (state_q != FLUSH);
    assign pc_write_en = ~eff_stall;
    assign idex_bubble = eff_stall;

    // NOTE: every variable gets a default before the branches so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        instr_d     = ifid_instr;
        pc_d        = ifid_pc;
        valid_d     = ifid_valid;
        load_nop    = 1'b0;

        if (flush_req) begin
            load_nop    = 1'b1;
            pc_d        = pc_in;
            flush_cnt_d = FLUSH_RELOAD;
            state_d     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else begin
            case (state_q)
                FLUSH: begin
                    load_nop    = 1'b1;
                    pc_d        = pc_in;
                    flush_cnt_d = flush_cnt_q - 4'd1;
                    if (flush_cnt_q <= 4'd1) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    if (eff_stall) begin
                        state_d = STALL;
                    end else begin
                        instr_d = instr_in;
                        pc_d    = pc_in;
                        valid_d = 1'b1;
                        state_d = RUN;
                    end
                end
            endcase
        end

        if (load_nop) begin
            instr_d = NOP;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            flush_cnt_q <= 4'd0;
            ifid_instr  <= NOP;
            ifid_pc     <= '0;
            ifid_valid  <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            ifid_instr  <= instr_d;
            ifid_pc     <= pc_d;
            ifid_valid  <= valid_d;
        end
    end

    stall_watchdog #(
        .STALL_MAX (STALL_MAX)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .stall   (eff_stall),
        .timeout (stall_timeout)
    );

`ifdef IF_ID_STALL_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_stall_cycles <= 32'd0;
            stat_flush_events <= 32'd0;
            stat_nops         <= 32'd0;
        end else begin
            if (eff_stall) stat_stall_cycles <= stat_stall_cycles + 32'd1;
            if (flush_req) stat_flush_events <= stat_flush_events + 32'd1;
            if (load_nop)  stat_nops         <= stat_nops + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_stall_ctrl.sv
// Directed self-checking bench for if_id_stall_ctrl (default parameters).
module tb_if_id_stall_ctrl;
    import pipe_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall_req;
    logic        flush_req;
    logic [15:0] instr_in;
    logic [15:0] pc_in;
    logic        pc_write_en;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic        ifid_valid;
    logic        idex_bubble;
    logic        stall_timeout;
`ifdef IF_ID_STALL_STATS_EN
    logic [31:0] stat_stall_cycles;
    logic [31:0] stat_flush_events;
    logic [31:0] stat_nops;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    if_id_stall_ctrl #(
        .IW (16), .AW (16), .FLUSH_CYCLES (2), .STALL_MAX (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .stall_req     (stall_req),
        .flush_req     (flush_req),
        .instr_in      (instr_in),
        .pc_in         (pc_in),
        .pc_write_en   (pc_write_en),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .ifid_valid    (ifid_valid),
        .idex_bubble   (idex_bubble),
        .stall_timeout (stall_timeout)
`ifdef IF_ID_STALL_STATS_EN
        ,
        .stat_stall_cycles (stat_stall_cycles),
        .stat_flush_events (stat_flush_events),
        .stat_nops         (stat_nops)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge so outputs are sampled away from it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic s, input logic f, input logic [15:0] i, input logic [15:0] p);
        stall_req = s;
        flush_req = f;
        instr_in  = i;
        pc_in     = p;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        #2;
        check("rst_instr",   32'(ifid_instr), 32'h0000);
        check("rst_valid",   32'(ifid_valid), 32'h0);
        check("rst_timeout", 32'(stall_timeout), 32'h0);
        check("rst_pcwe",    32'(pc_write_en), 32'h1);
        #10;
        reset = 1'b0;

        // Normal flow
        drive(1'b0, 1'b0, 16'h1234, 16'h0010);
        step();
        check("norm_instr", 32'(ifid_instr), 32'h1234);
        check("norm_pc",    32'(ifid_pc), 32'h0010);
        check("norm_valid", 32'(ifid_valid), 32'h1);
        check("norm_pcwe",  32'(pc_write_en), 32'h1);

        // Single-cycle stall while IF/ID holds 0xE345
        drive(1'b0, 1'b0, 16'hE345, 16'h0012);
        step();
        check("pre_stall_instr", 32'(ifid_instr), 32'hE345);
        drive(1'b1, 1'b0, 16'h5555, 16'h0014);
        #1;
        check("stall_pcwe",   32'(pc_write_en), 32'h0);
        check("stall_bubble", 32'(idex_bubble), 32'h1);
        step();
        check("stall_hold_instr", 32'(ifid_instr), 32'hE345);
        check("stall_hold_pc",    32'(ifid_pc), 32'h0012);
        check("stall_hold_valid", 32'(ifid_valid), 32'h1);
        stall_req = 1'b0;
        #1;
        check("unstall_pcwe", 32'(pc_write_en), 32'h1);
        step();
        check("unstall_instr", 32'(ifid_instr), 32'h5555);
        check("unstall_pc",    32'(ifid_pc), 32'h0014);

        // Two-cycle flush; a stall request inside FLUSH is ignored
        drive(1'b0, 1'b1, 16'h2222, 16'h0016);
        step();
        check("flush1_instr", 32'(ifid_instr), 32'h0000);
        check("flush1_valid", 32'(ifid_valid), 32'h0);
        drive(1'b1, 1'b0, 16'h3333, 16'h0018);
        #1;
        check("flush_ign_bubble", 32'(idex_bubble), 32'h0);
        check("flush_ign_pcwe",   32'(pc_write_en), 32'h1);
        step();
        check("flush2_instr", 32'(ifid_instr), 32'h0000);
        check("flush2_valid", 32'(ifid_valid), 32'h0);
        stall_req = 1'b0;
        step();
        check("flush_done_instr", 32'(ifid_instr), 32'h3333);
        check("flush_done_valid", 32'(ifid_valid), 32'h1);

        // Stall and flush in the same cycle resolve as flush
        drive(1'b1, 1'b1, 16'h4444, 16'h001A);
        #1;
        check("sf_bubble", 32'(idex_bubble), 32'h0);
        check("sf_pcwe",   32'(pc_write_en), 32'h1);
        step();
        check("sf_instr", 32'(ifid_instr), 32'h0000);
        check("sf_valid", 32'(ifid_valid), 32'h0);
        drive(1'b0, 1'b0, 16'h6666, 16'h001C);
        step();
        check("sf_flush2_instr", 32'(ifid_instr), 32'h0000);
        step();
        check("sf_done_instr", 32'(ifid_instr), 32'h6666);

        // Flush arriving while in STALL
        drive(1'b1, 1'b0, 16'h7777, 16'h001E);
        step();
        check("sflush_hold", 32'(ifid_instr), 32'h6666);
        flush_req = 1'b1;
        #1;
        check("sflush_bubble", 32'(idex_bubble), 32'h0);
        step();
        check("sflush_instr", 32'(ifid_instr), 32'h0000);
        drive(1'b0, 1'b0, 16'h7777, 16'h001E);
        step();
        check("sflush2_instr", 32'(ifid_instr), 32'h0000);
        step();
        check("sflush_done", 32'(ifid_instr), 32'h7777);

        // Watchdog: timeout raised on the 8th consecutive stall edge
        drive(1'b1, 1'b0, 16'h8888, 16'h0020);
        for (int i = 0; i < 7; i++) step();
        check("wd_before", 32'(stall_timeout), 32'h0);
        step();
        check("wd_at_8", 32'(stall_timeout), 32'h1);
        stall_req = 1'b0;
        step();
        check("wd_sticky",  32'(stall_timeout), 32'h1);
        check("wd_release", 32'(ifid_instr), 32'h8888);

        // Asynchronous reset mid-cycle clears everything immediately
        #2;
        reset = 1'b1;
        #1;
        check("arst_instr",   32'(ifid_instr), 32'h0000);
        check("arst_valid",   32'(ifid_valid), 32'h0);
        check("arst_timeout", 32'(stall_timeout), 32'h0);
        #2;
        reset = 1'b0;
        drive(1'b0, 1'b0, 16'h9ABC, 16'h0030);
        step();
        check("post_rst_instr", 32'(ifid_instr), 32'h9ABC);
        check("post_rst_valid", 32'(ifid_valid), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
